round_robin_selector: RTL and testbench

ROUND_ROBIN_SELECTOR -- requirements
Module: round_robin_selector

---
 rtl/round_robin_selector.sv | 143 ++++++++++++++
 tb/tb_round_robin_selector.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/round_robin_selector.sv
// Round-robin grant generator driving the select lines of a downstream 4:1 mux.
// Define SELECTOR_HOLD_EN to let one requester keep the grant for up to HOLD_MAX beats.
module round_robin_selector #(
    parameter int HOLD_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic req2,
    input  logic req3,
    input  logic advance,
    output logic address0,
    output logic address1,
    output logic grant0,
    output logic grant1,
    output logic grant2,
    output logic grant3,
    output logic valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  grant_q;
    logic        valid_q;
    logic [3:0]  req_v;
    logic        any_req;
    logic [1:0]  base;
    logic [1:0]  pick;
    logic        hold_keep;

    if (HOLD_MAX < 1 || HOLD_MAX > 7) begin : g_bad_hold_max
        $error("round_robin_selector: HOLD_MAX must be in 1..7");
    end

    assign req_v   = {req3, req2, req1, req0};
    assign any_req = |req_v;

    // While granting, the search restarts after the current grant, which is
    // the value the pointer takes when this beat completes.
    assign base = (state_q == GRANT) ? idx_q : ptr_q;

    always_comb begin
        logic found;
        logic [1:0] cand;
        pick  = base;
        found = 1'b0;
        cand  = base;
        for (int i = 1; i <= 4; i++) begin
            cand = base + 2'(i);
            if (!found && req_v[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

`ifdef SELECTOR_HOLD_EN
    logic [2:0] cnt_q;
    logic       new_grant;
    logic       keep_beat;

    assign hold_keep = req_v[idx_q] && (({1'b0, cnt_q} + 4'd1) < 4'(HOLD_MAX));
    assign keep_beat = (state_q == GRANT) && advance && hold_keep;
    assign new_grant = ((state_q == IDLE) && any_req) ||
                       ((state_q == GRANT) && advance && !hold_keep);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (keep_beat) begin
            cnt_q <= cnt_q + 3'd1;
        end else if (new_grant) begin
            cnt_q <= '0;
        end
    end
`else
    assign hold_keep = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    idx_d   = pick;
                end
            end
            GRANT: begin
                if (advance) begin
                    ptr_d = idx_q;
                    if (hold_keep) begin
                        idx_d = idx_q;
                    end else if (any_req) begin
                        idx_d = pick;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Outputs are registered from next-state so no input reaches a pin combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            ptr_q   <= 2'd3;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            valid_q <= (state_d == GRANT);
            grant_q <= (state_d == GRANT) ? (4'b0001 << idx_d) : 4'b0000;
        end
    end

    assign address0 = idx_q[0];
    assign address1 = idx_q[1];
    assign grant0   = grant_q[0];
    assign grant1   = grant_q[1];
    assign grant2   = grant_q[2];
    assign grant3   = grant_q[3];
    assign valid    = valid_q;

endmodule

// File: tb/tb_round_robin_selector.sv
// Directed testbench for round_robin_selector; covers the hold build when
// SELECTOR_HOLD_EN is defined (instance uses HOLD_MAX = 3).
module tb_round_robin_selector;

    localparam int HOLD = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic req0, req1, req2, req3;
    logic advance;
    logic address0, address1;
    logic grant0, grant1, grant2, grant3;
    logic valid;

    int vectors     = 0;
    int miscompares = 0;

    round_robin_selector #(.HOLD_MAX(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .req2     (req2),
        .req3     (req3),
        .advance  (advance),
        .address0 (address0),
        .address1 (address1),
        .grant0   (grant0),
        .grant1   (grant1),
        .grant2   (grant2),
        .grant3   (grant3),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] observed();
        return {valid, grant3, grant2, grant1, grant0, address1, address0};
    endfunction

    function automatic logic [6:0] expGrant(input int idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        return {1'b1, oh, 2'(idx)};
    endfunction

    // Expected index on step i of a continuous all-request rotation.
    function automatic int rotIdx(input int i);
`ifdef SELECTOR_HOLD_EN
        return (i / HOLD) % 4;
`else
        return i % 4;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [6:0] got, input logic [6:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b expected %b (valid,grant3..0,addr1..0)", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic adv);
        {req3, req2, req1, req0} = r;
        advance = adv;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int rotSteps;
        int pairExp[3];
        rst_n = 1'b0;
        {req3, req2, req1, req0} = 4'b0000;
        advance = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", observed(), 7'b0);
        rst_n = 1'b1;

        applyStimulus(4'b0100, 1'b0);
        checkOutput("req2_grant", observed(), expGrant(2));
        applyStimulus(4'b0100, 1'b0);
        checkOutput("req2_hold", observed(), expGrant(2));
        applyStimulus(4'b0000, 1'b0);
        checkOutput("req2_drop_hold", observed(), expGrant(2));
        applyStimulus(4'b0000, 1'b1);
        checkOutput("req2_release_idle", observed(), 7'b0);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("idle_advance_ignored", observed(), 7'b0);

        {req3, req2, req1, req0} = 4'b1111;
        #1;
        checkOutput("no_comb_path", observed(), 7'b0);

        applyStimulus(4'b0010, 1'b0);
        checkOutput("req1_grant", observed(), expGrant(1));
        applyStimulus(4'b0000, 1'b0);
        checkOutput("req1_drop_hold", observed(), expGrant(1));
        applyStimulus(4'b0000, 1'b1);
        checkOutput("req1_release_idle", observed(), 7'b0);

        pulseReset();
`ifdef SELECTOR_HOLD_EN
        rotSteps = 4 * HOLD - 1;
`else
        rotSteps = 8;
`endif
        for (int i = 0; i < rotSteps; i++) begin
            applyStimulus(4'b1111, 1'b1);
            checkOutput($sformatf("rotate%0d", i), observed(), expGrant(rotIdx(i)));
        end

        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_grant", observed(), 7'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1111, 1'b1);
        checkOutput("post_reset_first", observed(), expGrant(0));

        applyStimulus(4'b0001, 1'b1);
        checkOutput("sole_regrant_a", observed(), expGrant(0));
        applyStimulus(4'b0001, 1'b1);
        checkOutput("sole_regrant_b", observed(), expGrant(0));

`ifdef SELECTOR_HOLD_EN
        pairExp = '{1, 1, 1};
`else
        pairExp = '{1, 3, 1};
`endif
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1010, 1'b1);
            checkOutput($sformatf("pair13_%0d", i), observed(), expGrant(pairExp[i]));
        end
        applyStimulus(4'b0000, 1'b1);
        checkOutput("pair13_idle", observed(), 7'b0);

`ifdef SELECTOR_HOLD_EN
        pulseReset();
        for (int i = 0; i < 2 * HOLD + 1; i++) begin
            applyStimulus(4'b0011, 1'b1);
            checkOutput($sformatf("hold01_%0d", i), observed(), expGrant((i / HOLD) % 2));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
